// File: rtl/mem_pkg.sv
// Shared widths, funct3 encodings and packet formats for the memory issue pipe.
package mem_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 5;
    localparam int PHY_WIDTH  = 6;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                  is_load;
        logic                  is_store;
        logic [2:0]            funct3;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] data;
        logic [ROB_WIDTH-1:0]  rob_id;
        logic [PHY_WIDTH-1:0]  rd_phy;
    } mem_op_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            strb;
        logic [ROB_WIDTH-1:0]  rob_id;
    } st_pkt_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            funct3;
        logic [3:0]            strb;
        logic [ROB_WIDTH-1:0]  rob_id;
        logic [PHY_WIDTH-1:0]  rd_phy;
    } ld_pkt_t;

    // Unshifted byte-lane mask for the access size; the reserved size 11 acts as a word.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/agu_fifo.sv
// Purpose: generic DEPTH-entry FIFO with synchronous flush; head shown combinationally, zero when empty.
// Latency: an entry pushed at an edge is at the head right after that edge.
// Backpressure: full blocks further pushes; pop is ignored while empty.
module agu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mem_agu_pipe.sv
// Purpose: effective-address, strobe and alignment generation feeding separate store and load queues.
// Latency: one cycle from issue acceptance to queue head or exc_valid pulse.
// Backpressure: in_ready drops when the target queue is full, or while flush/rst is high.
module mem_agu_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  mem_op_t               in_op,
    output logic                  st_valid,
    input  logic                  st_ready,
    output st_pkt_t               st_pkt,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output ld_pkt_t               ld_pkt,
    output logic                  exc_valid,
    output logic [ROB_WIDTH-1:0]  exc_rob_id,
    output logic [ADDR_WIDTH-1:0] exc_addr
);

    logic [ADDR_WIDTH-1:0] ea;
    logic [1:0]            off;
    logic [3:0]            mask;
    logic [7:0]            strb_wide;
    logic [DATA_WIDTH-1:0] data_sized;
    logic                  misaligned;
    logic                  st_sel, ld_sel, trap;
    logic                  accept, st_push, ld_push;
    logic                  st_full, st_empty, ld_full, ld_empty;
    st_pkt_t               st_in;
    ld_pkt_t               ld_in;

    assign ea        = in_op.base + in_op.imm;
    assign off       = ea[1:0];
    assign mask      = size_mask(in_op.funct3[1:0]);
    assign strb_wide = {4'b0000, mask} << off;

    always_comb begin
        data_sized = in_op.data;
        misaligned = (off != 2'b00);
        case (in_op.funct3[1:0])
            F3_SB[1:0]: begin
                data_sized = {24'h0, in_op.data[7:0]};
                misaligned = 1'b0;
            end
            F3_SH[1:0]: begin
                data_sized = {16'h0, in_op.data[15:0]};
                misaligned = off[0];
            end
            default: ;
        endcase
    end

    // A set store bit wins, so an op flagged as both is treated as a store.
    assign st_sel = in_op.is_store;
    assign ld_sel = in_op.is_load && !in_op.is_store;
    assign trap   = (MISALIGN_TRAP != 0) && (st_sel || ld_sel) && misaligned;

    // Trapping ops never touch a queue, so they are accepted even when it is full.
    assign in_ready = !rst && !flush &&
                      (trap || (st_sel ? !st_full : (ld_sel ? !ld_full : 1'b1)));
    assign accept   = in_valid && in_ready;
    assign st_push  = accept && st_sel && !trap;
    assign ld_push  = accept && ld_sel && !trap;

    always_comb begin
        st_in        = '0;
        st_in.addr   = ea;
        st_in.data   = data_sized << {off, 3'b000};
        st_in.strb   = strb_wide[3:0];
        st_in.rob_id = in_op.rob_id;
        ld_in        = '0;
        ld_in.addr   = ea;
        ld_in.funct3 = in_op.funct3;
        ld_in.strb   = strb_wide[3:0];
        ld_in.rob_id = in_op.rob_id;
        ld_in.rd_phy = in_op.rd_phy;
    end

    agu_fifo #(.WIDTH($bits(st_pkt_t)), .DEPTH(DEPTH)) u_st_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (st_push),
        .push_dat (st_in),
        .pop      (st_valid && st_ready),
        .pop_dat  (st_pkt),
        .full     (st_full),
        .empty    (st_empty)
    );

    agu_fifo #(.WIDTH($bits(ld_pkt_t)), .DEPTH(DEPTH)) u_ld_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (ld_push),
        .push_dat (ld_in),
        .pop      (ld_valid && ld_ready),
        .pop_dat  (ld_pkt),
        .full     (ld_full),
        .empty    (ld_empty)
    );

    assign st_valid = !st_empty;
    assign ld_valid = !ld_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_valid  <= 1'b0;
            exc_rob_id <= '0;
            exc_addr   <= '0;
        end else begin
            exc_valid <= accept && trap;
            if (accept && trap) begin
                exc_rob_id <= in_op.rob_id;
                exc_addr   <= ea;
            end
        end
    end

endmodule

// File: tb/tb_mem_agu_pipe.sv
// Directed scoreboard bench: issue pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_mem_agu_pipe;
    import mem_pkg::*;

    typedef struct { st_pkt_t p; int due; } st_exp_t;
    typedef struct { ld_pkt_t p; int due; } ld_exp_t;
    typedef struct { logic [ROB_WIDTH-1:0] rob; logic [ADDR_WIDTH-1:0] addr; int due; } exc_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0, in_ready;
    mem_op_t in_op = '0;
    logic st_valid, st_ready = 1'b1;
    st_pkt_t st_pkt;
    logic ld_valid, ld_ready = 1'b1;
    ld_pkt_t ld_pkt;
    logic exc_valid;
    logic [ROB_WIDTH-1:0] exc_rob_id;
    logic [ADDR_WIDTH-1:0] exc_addr;

    logic flush0 = 1'b0;
    logic in_valid0 = 1'b0, in_ready0;
    mem_op_t in_op0 = '0;
    logic st_valid0, st_ready0 = 1'b1;
    st_pkt_t st_pkt0;
    logic ld_valid0, ld_ready0 = 1'b1;
    ld_pkt_t ld_pkt0;
    logic exc_valid0;
    logic [ROB_WIDTH-1:0] exc_rob_id0;
    logic [ADDR_WIDTH-1:0] exc_addr0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    st_exp_t  st_exp[$];
    ld_exp_t  ld_exp[$];
    exc_exp_t exc_exp[$];

    mem_agu_pipe #(.DEPTH(2), .MISALIGN_TRAP(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .st_valid(st_valid), .st_ready(st_ready), .st_pkt(st_pkt),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_pkt(ld_pkt),
        .exc_valid(exc_valid), .exc_rob_id(exc_rob_id), .exc_addr(exc_addr)
    );

    mem_agu_pipe #(.DEPTH(2), .MISALIGN_TRAP(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_op(in_op0), .st_valid(st_valid0), .st_ready(st_ready0), .st_pkt(st_pkt0),
        .ld_valid(ld_valid0), .ld_ready(ld_ready0), .ld_pkt(ld_pkt0),
        .exc_valid(exc_valid0), .exc_rob_id(exc_rob_id0), .exc_addr(exc_addr0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic mem_op_t mk_op(input bit ld, input bit st, input logic [2:0] f3,
                                      input logic [31:0] base, input logic [31:0] imm,
                                      input logic [31:0] data, input logic [4:0] rob,
                                      input logic [5:0] rd);
        mem_op_t o;
        o = '{is_load: ld, is_store: st, funct3: f3, base: base, imm: imm,
              data: data, rob_id: rob, rd_phy: rd};
        return o;
    endfunction

    function automatic st_pkt_t sp(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input logic [4:0] r);
        st_pkt_t p;
        p = '{addr: a, data: d, strb: s, rob_id: r};
        return p;
    endfunction

    function automatic ld_pkt_t lp(input logic [31:0] a, input logic [2:0] f3,
                                   input logic [3:0] s, input logic [4:0] r, input logic [5:0] rd);
        ld_pkt_t p;
        p = '{addr: a, funct3: f3, strb: s, rob_id: r, rd_phy: rd};
        return p;
    endfunction

    // kind: 0 nothing expected, 1 store, 2 load, 3 exception (rob/addr taken from es)
    task automatic issue(input mem_op_t op, input bit exp_rdy, input int kind,
                         input st_pkt_t es, input ld_pkt_t el, input string nm);
        bit acc;
        in_op = op;
        in_valid = 1'b1;
        #3;
        acc = in_ready;
        chk(in_ready === exp_rdy, {nm, "_in_ready"}, in_ready, exp_rdy);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) begin
            case (kind)
                1: st_exp.push_back('{p: es, due: cyc});
                2: ld_exp.push_back('{p: el, due: cyc});
                3: exc_exp.push_back('{rob: es.rob_id, addr: es.addr, due: cyc});
                default: ;
            endcase
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (st_valid) begin
                if (st_exp.size() == 0) chk(1'b0, "st_unexpected", st_pkt, 0);
                else begin
                    chk(st_pkt === st_exp[0].p && cyc >= st_exp[0].due, "st_pkt", st_pkt, st_exp[0].p);
                    if (st_ready) void'(st_exp.pop_front());
                end
            end
            if (ld_valid) begin
                if (ld_exp.size() == 0) chk(1'b0, "ld_unexpected", ld_pkt, 0);
                else begin
                    chk(ld_pkt === ld_exp[0].p && cyc >= ld_exp[0].due, "ld_pkt", ld_pkt, ld_exp[0].p);
                    if (ld_ready) void'(ld_exp.pop_front());
                end
            end
            if (exc_valid) begin
                if (exc_exp.size() == 0) chk(1'b0, "exc_unexpected", {exc_rob_id, exc_addr}, 0);
                else begin
                    chk(exc_rob_id === exc_exp[0].rob && exc_addr === exc_exp[0].addr
                        && cyc == exc_exp[0].due, "exc",
                        {exc_rob_id, exc_addr}, {exc_exp[0].rob, exc_exp[0].addr});
                    void'(exc_exp.pop_front());
                end
            end else if (exc_exp.size() != 0 && cyc > exc_exp[0].due) begin
                chk(1'b0, "exc_missing", 0, {exc_exp[0].rob, exc_exp[0].addr});
                void'(exc_exp.pop_front());
            end
            if (exc_valid0) chk(1'b0, "exc_notrap_unexpected", exc_addr0, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        in_op = mk_op(0, 0, 3'b000, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        #3;
        chk(in_ready === 1'b0, "rst_in_ready", in_ready, 0);
        chk({st_valid, ld_valid, exc_valid} === 3'b000, "rst_valids", {st_valid, ld_valid, exc_valid}, 0);
        chk(st_pkt === '0, "rst_st_pkt", st_pkt, 0);
        chk(ld_pkt === '0, "rst_ld_pkt", ld_pkt, 0);
        chk({exc_rob_id, exc_addr} === '0, "rst_exc_fields", {exc_rob_id, exc_addr}, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;

        // Main function
        issue(mk_op(0, 1, F3_SB, 32'h1000, 32'h3, 32'hA5, 5'd1, 6'd0), 1, 1,
              sp(32'h1003, 32'hA500_0000, 4'b1000, 5'd1), '0, "sb_off3");
        issue(mk_op(1, 0, F3_LHU, 32'h2001, 32'h1, 32'h0, 5'd2, 6'h2A), 1, 2,
              '0, lp(32'h2002, 3'b101, 4'b1100, 5'd2, 6'h2A), "lhu");
        issue(mk_op(0, 1, F3_SH, 32'h10, 32'h2, 32'h1234_BEEF, 5'd3, 6'd0), 1, 1,
              sp(32'h12, 32'hBEEF_0000, 4'b1100, 5'd3), '0, "sh_off2");
        issue(mk_op(0, 1, F3_SW, 32'h4000, 32'h8, 32'hDEAD_BEEF, 5'd4, 6'd0), 1, 1,
              sp(32'h4008, 32'hDEAD_BEEF, 4'b1111, 5'd4), '0, "sw");
        issue(mk_op(1, 0, F3_LW, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd5, 6'd5), 1, 2,
              '0, lp(32'h4, 3'b010, 4'b1111, 5'd5, 6'd5), "lw_wrap");
        issue(mk_op(1, 0, F3_LB, 32'h101, 32'h0, 32'h0, 5'd6, 6'h3F), 1, 2,
              '0, lp(32'h101, 3'b000, 4'b0010, 5'd6, 6'h3F), "lb_off1");
        issue(mk_op(1, 0, F3_LBU, 32'h100, 32'hFFFF_FFFF, 32'h0, 5'd11, 6'd1), 1, 2,
              '0, lp(32'hFF, 3'b100, 4'b1000, 5'd11, 6'd1), "lbu_negimm");
        issue(mk_op(0, 0, F3_SW, 32'h3000, 32'h2, 32'h0, 5'd9, 6'd0), 1, 0, '0, '0, "noop");
        issue(mk_op(1, 1, F3_SB, 32'h21, 32'h0, 32'h77, 5'd10, 6'd0), 1, 1,
              sp(32'h21, 32'h0000_7700, 4'b0010, 5'd10), '0, "both_is_store");
        issue(mk_op(0, 1, F3_SW, 32'h3000, 32'h2, 32'h0, 5'd7, 6'd0), 1, 3,
              sp(32'h3002, 0, 4'b0, 5'd7), '0, "sw_trap");
        issue(mk_op(1, 0, F3_LH, 32'h5001, 32'h0, 32'h0, 5'd8, 6'd0), 1, 3,
              sp(32'h5001, 0, 4'b0, 5'd8), '0, "lh_trap");
        tick(2);

        // Store backpressure
        st_ready = 1'b0;
        issue(mk_op(0, 1, F3_SB, 32'h40, 32'h0, 32'h11, 5'd12, 6'd0), 1, 1,
              sp(32'h40, 32'h11, 4'b0001, 5'd12), '0, "bp_s1");
        issue(mk_op(0, 1, F3_SB, 32'h41, 32'h0, 32'h22, 5'd13, 6'd0), 1, 1,
              sp(32'h41, 32'h2200, 4'b0010, 5'd13), '0, "bp_s2");
        issue(mk_op(0, 1, F3_SB, 32'h42, 32'h0, 32'h33, 5'd14, 6'd0), 0, 0, '0, '0, "bp_s3_full");
        issue(mk_op(0, 1, F3_SW, 32'h3000, 32'h2, 32'h0, 5'd15, 6'd0), 1, 3,
              sp(32'h3002, 0, 4'b0, 5'd15), '0, "trap_when_full");
        issue(mk_op(1, 0, F3_LW, 32'h80, 32'h0, 32'h0, 5'd16, 6'd2), 1, 2,
              '0, lp(32'h80, 3'b010, 4'b1111, 5'd16, 6'd2), "ld_while_st_full");
        tick(2);
        st_ready = 1'b1;
        tick(3);
        issue(mk_op(0, 1, F3_SB, 32'h43, 32'h0, 32'h44, 5'd17, 6'd0), 1, 1,
              sp(32'h43, 32'h4400_0000, 4'b1000, 5'd17), '0, "pp_s4");
        issue(mk_op(0, 1, F3_SH, 32'h44, 32'h0, 32'h5566, 5'd18, 6'd0), 1, 1,
              sp(32'h44, 32'h5566, 4'b0011, 5'd18), '0, "pp_s5");
        tick(3);

        // Flush with two loads queued
        ld_ready = 1'b0;
        issue(mk_op(1, 0, F3_LW, 32'h90, 32'h0, 32'h0, 5'd19, 6'd3), 1, 2,
              '0, lp(32'h90, 3'b010, 4'b1111, 5'd19, 6'd3), "fl_l1");
        issue(mk_op(1, 0, F3_LB, 32'h93, 32'h0, 32'h0, 5'd20, 6'd4), 1, 2,
              '0, lp(32'h93, 3'b000, 4'b1000, 5'd20, 6'd4), "fl_l2");
        flush = 1'b1;
        issue(mk_op(1, 0, F3_LW, 32'hA0, 32'h0, 32'h0, 5'd21, 6'd5), 0, 0, '0, '0, "flush_new_op");
        flush = 1'b0;
        ld_exp.delete();
        #3;
        chk(ld_valid === 1'b0, "flush_ld_valid", ld_valid, 0);
        tick(1);
        flush = 1'b1;
        issue(mk_op(0, 1, F3_SW, 32'h3000, 32'h2, 32'h0, 5'd22, 6'd0), 0, 0, '0, '0, "flush_trap_op");
        flush = 1'b0;
        ld_ready = 1'b1;
        tick(3);

        // Reset with both queues occupied
        st_ready = 1'b0;
        ld_ready = 1'b0;
        issue(mk_op(0, 1, F3_SB, 32'h50, 32'h0, 32'h1, 5'd23, 6'd0), 1, 1,
              sp(32'h50, 32'h1, 4'b0001, 5'd23), '0, "pre_rst_st");
        issue(mk_op(1, 0, F3_LB, 32'h60, 32'h0, 32'h0, 5'd24, 6'd6), 1, 2,
              '0, lp(32'h60, 3'b000, 4'b0001, 5'd24, 6'd6), "pre_rst_ld");
        rst = 1'b1;
        in_op = mk_op(0, 1, F3_SB, 32'h58, 32'h0, 32'h9, 5'd30, 6'd0);
        in_valid = 1'b1;
        #3;
        chk(in_ready === 1'b0, "midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        st_exp.delete();
        ld_exp.delete();
        exc_exp.delete();
        #3;
        chk({st_valid, ld_valid, exc_valid} === 3'b000, "midrst_valids", {st_valid, ld_valid, exc_valid}, 0);
        chk({st_pkt, ld_pkt} === '0, "midrst_pkts", {st_pkt, ld_pkt}, 0);
        in_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        st_ready = 1'b1;
        ld_ready = 1'b1;
        issue(mk_op(0, 1, F3_SB, 32'h70, 32'h0, 32'h9A, 5'd25, 6'd0), 1, 1,
              sp(32'h70, 32'h9A, 4'b0001, 5'd25), '0, "post_rst_st");
        #3;
        chk(st_valid === 1'b1, "post_rst_latency", st_valid, 1);
        tick(2);

        // Non-trapping instance forwards misaligned ops
        in_op0 = mk_op(0, 1, F3_SW, 32'h3000, 32'h2, 32'hCAFE_F00D, 5'd26, 6'd0);
        in_valid0 = 1'b1;
        #3;
        chk(in_ready0 === 1'b1, "notrap_sw_in_ready", in_ready0, 1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        #3;
        chk(st_valid0 === 1'b1 && st_pkt0 === sp(32'h3002, 32'hF00D_0000, 4'b1100, 5'd26),
            "notrap_sw_pkt", {st_valid0, st_pkt0}, {1'b1, sp(32'h3002, 32'hF00D_0000, 4'b1100, 5'd26)});
        tick(1);
        in_op0 = mk_op(1, 0, F3_LH, 32'h5001, 32'h0, 32'h0, 5'd27, 6'd7);
        in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        #3;
        chk(ld_valid0 === 1'b1 && ld_pkt0 === lp(32'h5001, 3'b001, 4'b0110, 5'd27, 6'd7),
            "notrap_lh_pkt", {ld_valid0, ld_pkt0}, {1'b1, lp(32'h5001, 3'b001, 4'b0110, 5'd27, 6'd7)});
        chk(exc_valid0 === 1'b0, "notrap_no_exc", exc_valid0, 0);
        tick(4);

        chk(st_exp.size() == 0, "st_drained", st_exp.size(), 0);
        chk(ld_exp.size() == 0, "ld_drained", ld_exp.size(), 0);
        chk(exc_exp.size() == 0, "exc_drained", exc_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_agu_pipe.md
MEM_AGU_PIPE -- requirements
Module: mem_agu_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2: entries per output queue; power of two, at least 2.
REQ-002 SHALL have parameter MISALIGN_TRAP, default 1: 1 traps misaligned accesses, 0 forwards them.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1: kill all queued and incoming operations.
REQ-006 SHALL have port in_valid, input, 1: issue operation present.
REQ-007 SHALL have port in_ready, output, 1: issue operation accepted this cycle when in_valid is high.
REQ-008 SHALL have port in_op, input, mem_op_t: is_load, is_store, funct3[2:0], base, imm, data, rob_id, rd_phy.
REQ-009 SHALL have port st_valid, output, 1: store queue head valid.
REQ-010 SHALL have port st_ready, input, 1: store consumer accepts head.
REQ-011 SHALL have port st_pkt, output, st_pkt_t: addr, data, strb[3:0], rob_id.
REQ-012 SHALL have port ld_valid, output, 1: load queue head valid.
REQ-013 SHALL have port ld_ready, input, 1: load consumer accepts head.
REQ-014 SHALL have port ld_pkt, output, ld_pkt_t: addr, funct3, strb[3:0], rob_id, rd_phy.
REQ-015 SHALL have port exc_valid, output, 1: one-cycle misaligned-access pulse.
REQ-016 SHALL have port exc_rob_id, output, ROB_WIDTH: rob_id of the faulting operation.
REQ-017 SHALL have port exc_addr, output, ADDR_WIDTH: faulting effective address.

Function
REQ-018 SHALL compute ea = base + imm, modulo 2^ADDR_WIDTH, with no overflow flag.
REQ-019 SHALL drive in_ready = !flush && (is_store ? !st_full : is_load ? !ld_full : 1); the queue's pop in the same cycle SHALL NOT be used (no bypass).
REQ-020 SHALL treat an accepted op with neither is_load nor is_store as a no-op; both set SHALL be handled as a store.
REQ-021 SHALL set size = 1/2/4 bytes for funct3[1:0] = 00/01/10, with off = ea[1:0].
REQ-022 SHALL form strb = ((1<<size)-1) << off, truncated to 4 bits.
REQ-023 SHALL form st data = data[8*size-1:0] << (8*off), truncated to 32 bits; SB at off 3 puts data[7:0] in bits 31:24.
REQ-024 SHALL define misaligned as (size 2 and off[0]) or (size 4 and off != 0).
REQ-025 SHALL, when MISALIGN_TRAP=1, not enqueue a misaligned op; it SHALL raise exc_valid one cycle after acceptance with rob_id and ea, and it SHALL need no queue space.
REQ-026 SHALL, when MISALIGN_TRAP=0, enqueue misaligned ops normally with truncated strb/data and never assert exc_valid.
REQ-027 SHALL give an accepted op at least one cycle of latency: it is visible on st_/ld_ outputs no earlier than the next cycle.
REQ-028 SHALL keep each queue FIFO-ordered, popping on valid&&ready and pushing on accept; simultaneous push and pop SHALL keep the count, and pointers SHALL wrap at DEPTH.
REQ-029 SHALL hold payload stable while valid is high and ready is low.
REQ-030 SHALL, on flush, empty both queues next cycle, accept nothing that cycle, and suppress any exc_valid that would be produced.
REQ-031 SHALL leave loads and stores unordered relative to each other; ordering is the LSQ's responsibility.

Reset
REQ-032 SHALL, with rst high at a clock edge, empty both queues and drive st_valid, ld_valid, exc_valid low and st_pkt, ld_pkt, exc_rob_id, exc_addr to zero.
REQ-033 SHALL discard in-flight operations on reset mid-operation; in_ready is low while rst is high.

Structure
REQ-034 SHALL place in mem_pkg: ADDR_WIDTH=32, DATA_WIDTH=32, ROB_WIDTH=5, PHY_WIDTH=6, the SB/SH/SW/LB/LH/LW/LBU/LHU funct3 constants, and mem_op_t, st_pkt_t, ld_pkt_t.
REQ-035 SHALL contain one generic sub-module, agu_fifo (param WIDTH, DEPTH; push/pop/full/empty/flush), instantiated once for stores and once for loads.
REQ-036 SHALL keep address, strobe and alignment logic combinational in mem_agu_pipe ahead of the queues.

Verification
REQ-037 SB, base=0x1000, imm=3, data=0xA5 -> next cycle st_valid, addr 0x1003, data 0xA5000000, strb 1000.
REQ-038 LHU, base=0x2001, imm=1 -> ld_pkt addr 0x2002, strb 1100, funct3 101, rd_phy preserved.
REQ-039 SW at ea 0x3002, MISALIGN_TRAP=1 -> exc_valid pulse with exc_addr 0x3002 and no st_valid; with MISALIGN_TRAP=0 -> st_valid with strb 1100, no exc.
REQ-040 st_ready=0, issue 3 stores with DEPTH=2 -> third sees in_ready=0; raising st_ready drains in order; push and pop at full keeps count=2.
REQ-041 Two loads queued and flush asserted with a new valid op -> ld_valid low next cycle, new op not accepted, no exc.
REQ-042 rst asserted while both queues are nonempty -> all valids low and packets zero after the edge; first op after release appears one cycle after acceptance.
